rv_instr_encoder: RTL and testbench

Streaming RV32I instruction encoder, the inverse of the instruction decoder. It accepts decoded fields (instruction class, funct3, funct7, register indices, 32-bit immediate) and packs them into 32-bit RV32I machine words. Each word is tagged with a sequential instruction-memory address and an immediate-range error bit, then presented on a valid/ready output through a 2-entry buffer. It sits between the test/program generator and the instruction-memory loader.

---
 rtl/rv_instr_encoder_if.sv | 32 +++
 rtl/rv_instr_encoder.sv | 122 ++++++++++++
 tb/tb_rv_instr_encoder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_instr_encoder_if.sv
// Valid/ready field-in / word-out bus of the RV32I instruction encoder.
// master = field producer and word consumer, slave = encoder.
interface rv_instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        funct;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [31:0]       imm;
  logic              addr_clr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic              err_flag;

  modport master (
    output in_valid, funct, funct3, funct7, rs1, rs2, rd, imm, addr_clr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_flag
  );

  modport slave (
    input  in_valid, funct, funct3, funct7, rs1, rs2, rd, imm, addr_clr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_flag
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I encoder: packs decoded fields into machine words, flags
// out-of-range immediates, and emits {word, addr, err} through a 2-entry FIFO.
module rv_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input logic               i_clk,
  input logic               i_rst,
  rv_instr_encoder_if.slave bus
);
  localparam logic [ADDR_W-1:0] L_BASE = BASE_ADDR[ADDR_W-1:0];

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } ent_t;

  logic [31:0]       w_instr;
  logic              w_err;
  logic              w_shift;
  logic              w_fit12;
  logic              w_fit13;
  logic              w_fit21;
  logic              w_push;
  logic              w_pop;
  logic              w_out_valid;
  logic              w_in_ready;
  ent_t              w_head;

  ent_t              r_mem [2];
  logic              r_wr;
  logic              r_rd;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err_flag;

  // An immediate fits N signed bits when all bits from N-1 upward agree.
  assign w_fit12 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign w_fit13 = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
  assign w_fit21 = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);
  assign w_shift = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);

  always_comb begin
    w_instr = '0;
    w_err   = 1'b0;
    case (bus.funct)
      3'd0: w_instr = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
      3'd1: begin
        if (w_shift) begin
          w_instr = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
          w_err   = |bus.imm[31:5];
        end else begin
          w_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
          w_err   = ~w_fit12;
        end
      end
      3'd2: begin
        w_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0000011};
        w_err   = ~w_fit12;
      end
      3'd3: begin
        w_instr = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b1100111};
        w_err   = ~w_fit12;
      end
      3'd4: begin
        w_instr = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], 7'b0100011};
        w_err   = ~w_fit12;
      end
      3'd5: begin
        w_instr = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                   bus.imm[4:1], bus.imm[11], 7'b1100011};
        w_err   = ~w_fit13 | bus.imm[0];
      end
      3'd6: begin
        w_instr = {bus.imm[31:12], bus.rd, 7'b0110111};
        w_err   = |bus.imm[11:0];
      end
      default: begin
        w_instr = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, 7'b1101111};
        w_err   = ~w_fit21 | bus.imm[0];
      end
    endcase
  end

  // in_ready comes from the registered count only, never from out_ready.
  assign w_in_ready  = ~r_cnt[1];
  assign w_out_valid = |r_cnt;
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;
  assign w_head      = r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_cnt      <= 2'd0;
      r_addr     <= L_BASE;
      r_err_flag <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= '{instr: w_instr, err: w_err};
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 2'd1;
      // A clear wins over the increment; the word popped now keeps its old tag.
      if (bus.addr_clr)  r_addr <= L_BASE;
      else if (w_pop)    r_addr <= r_addr + ADDR_W'(4);
      if (w_pop && w_head.err) r_err_flag <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_out_valid ? w_head.instr : 32'd0;
  assign bus.out_err   = w_out_valid & w_head.err;
  assign bus.out_addr  = r_addr;
  assign bus.err_flag  = r_err_flag;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed literal encodes plus randomized traffic
// against a behavioural model; a second instance (4-bit counter, base 0xC) shadows the first.
module tb_rv_instr_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_instr_encoder_if #(.ADDR_W(32)) b1();
  rv_instr_encoder_if #(.ADDR_W(4))  b2();

  rv_instr_encoder #(.BASE_ADDR(32'h0), .ADDR_W(32)) u_dut (.i_clk(clk), .i_rst(rst), .bus(b1));
  rv_instr_encoder #(.BASE_ADDR(32'hC), .ADDR_W(4))  u_dut4 (.i_clk(clk), .i_rst(rst), .bus(b2));

  assign b2.in_valid  = b1.in_valid;
  assign b2.funct     = b1.funct;
  assign b2.funct3    = b1.funct3;
  assign b2.funct7    = b1.funct7;
  assign b2.rs1       = b1.rs1;
  assign b2.rs2       = b1.rs2;
  assign b2.rd        = b1.rd;
  assign b2.imm       = b1.imm;
  assign b2.addr_clr  = b1.addr_clr;
  assign b2.out_ready = b1.out_ready;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", n, a, e);
    end
  endtask

  // Reference encoder: field placement by bit position, range checks by signed arithmetic.
  function automatic logic [32:0] ref_enc(input logic [2:0] c, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] r1,
                                          input logic [4:0] r2, input logic [4:0] d,
                                          input logic [31:0] imm);
    logic [31:0] w;
    logic        e;
    int          s;
    s = $signed(imm);
    w = 32'd0;
    e = 1'b0;
    case (c)
      3'd0: begin
        w[6:0] = 7'h33; w[11:7] = d; w[14:12] = f3; w[19:15] = r1; w[24:20] = r2; w[31:25] = f7;
      end
      3'd1, 3'd2, 3'd3: begin
        w[6:0] = (c == 3'd1) ? 7'h13 : (c == 3'd2) ? 7'h03 : 7'h67;
        w[11:7] = d; w[14:12] = (c == 3'd3) ? 3'd0 : f3; w[19:15] = r1; w[31:20] = imm[11:0];
        if (c == 3'd1 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w[24:20] = imm[4:0]; w[31:25] = f7; e = (imm > 32'd31);
        end else e = !(s >= -2048 && s <= 2047);
      end
      3'd4: begin
        w[6:0] = 7'h23; w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = r1; w[24:20] = r2;
        w[31:25] = imm[11:5]; e = !(s >= -2048 && s <= 2047);
      end
      3'd5: begin
        w[6:0] = 7'h63; w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3; w[19:15] = r1;
        w[24:20] = r2; w[30:25] = imm[10:5]; w[31] = imm[12];
        e = !(s >= -4096 && s <= 4095) || ((imm % 2) != 0);
      end
      3'd6: begin
        w[6:0] = 7'h37; w[11:7] = d; w[31:12] = imm[31:12]; e = ((imm % 4096) != 0);
      end
      default: begin
        w[6:0] = 7'h6F; w[11:7] = d; w[19:12] = imm[19:12]; w[20] = imm[11];
        w[30:21] = imm[10:1]; w[31] = imm[20];
        e = !(s >= -1048576 && s <= 1048575) || ((imm % 2) != 0);
      end
    endcase
    return {e, w};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_addr  = 32'd0;
  logic [3:0]  m_addr4 = 4'hC;
  logic        m_flag  = 1'b0;
  bit          m_live  = 1'b0;

  // Model state always describes the DUT after the most recent rising edge.
  always @(negedge clk) begin
    logic        do_push;
    logic        do_pop;
    logic [32:0] e;
    if (m_live) begin
      chk("out_valid", b1.out_valid, q.size() > 0);
      chk("in_ready", b1.in_ready, q.size() < 2);
      chk("err_flag", b1.err_flag, m_flag);
      chk("out_addr", b1.out_addr, m_addr);
      chk("out_addr4", 32'(b2.out_addr), 32'(m_addr4));
      if (q.size() > 0) begin
        chk("out_instr", b1.out_instr, q[0].instr);
        chk("out_err", b1.out_err, q[0].err);
      end
    end
    if (rst) begin
      q.delete();
      m_addr  = 32'd0;
      m_addr4 = 4'hC;
      m_flag  = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      do_push = b1.in_valid && (q.size() < 2);
      do_pop  = (q.size() > 0) && b1.out_ready;
      e = ref_enc(b1.funct, b1.funct3, b1.funct7, b1.rs1, b1.rs2, b1.rd, b1.imm);
      if (do_pop) begin
        if (q[0].err) m_flag = 1'b1;
        void'(q.pop_front());
      end
      if (do_push) q.push_back('{instr: e[31:0], err: e[32]});
      if (b1.addr_clr) begin
        m_addr  = 32'd0;
        m_addr4 = 4'hC;
      end else if (do_pop) begin
        m_addr  = m_addr + 32'd4;
        m_addr4 = m_addr4 + 4'd4;
      end
    end
  end

  task automatic drv(input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                     input logic [31:0] imm);
    b1.funct = c; b1.funct3 = f3; b1.funct7 = f7;
    b1.rs1 = r1; b1.rs2 = r2; b1.rd = d; b1.imm = imm;
  endtask

  task automatic lit(input string n, input logic [2:0] c, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] d, input logic [31:0] imm,
                     input logic [31:0] ex, input logic exe);
    logic [32:0] m;
    m = ref_enc(c, f3, f7, r1, r2, d, imm);
    chk({n, "_model"}, m[31:0], ex);
    chk({n, "_model_err"}, m[32], exe);
    @(posedge clk); #1;
    drv(c, f3, f7, r1, r2, d, imm);
    b1.in_valid = 1'b1; b1.out_ready = 1'b1; b1.addr_clr = 1'b0;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    @(negedge clk);
    chk(n, b1.out_instr, ex);
    chk({n, "_err"}, b1.out_err, exe);
  endtask

  logic [31:0] bnd [14] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4095,
                           32'hFFFFF000, 32'd31, 32'd32, 32'h1000, 32'hFFFFF000,
                           32'd1048574, 32'd1048576, 32'hFFF00000};

  initial begin
    b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.addr_clr = 1'b0;
    drv(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", b1.out_valid, 1'b0);
    chk("rst_ready", b1.in_ready, 1'b1);
    chk("rst_instr", b1.out_instr, 32'd0);
    chk("rst_err", b1.out_err, 1'b0);
    chk("rst_addr", b1.out_addr, 32'd0);
    chk("rst_addr4", 32'(b2.out_addr), 32'hC);
    chk("rst_flag", b1.err_flag, 1'b0);

    lit("addi",  3'd1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5,        32'h00500093, 1'b0);
    lit("add",   3'd0, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0,        32'h002081B3, 1'b0);
    lit("sw",    3'd4, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8,        32'h0020A423, 1'b0);
    lit("beq",   3'd5, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    lit("jal",   3'd7, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h800,      32'h001000EF, 1'b0);
    lit("lui",   3'd6, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000, 32'h123452B7, 1'b0);
    chk("flag_clean", b1.err_flag, 1'b0);
    lit("i_rng", 3'd1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048,     32'h80000013, 1'b1);
    lit("b_ev6", 3'd5, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd6,        32'h00000363, 1'b0);
    chk("flag_set", b1.err_flag, 1'b1);
    lit("b_odd", 3'd5, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3,        32'h00000163, 1'b1);
    chk("flag_sticky", b1.err_flag, 1'b1);

    // Reset while two words are buffered.
    @(posedge clk); #1;
    b1.out_ready = 1'b0; b1.in_valid = 1'b1; drv(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd9, 32'd0);
    @(posedge clk); #1;
    drv(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd10, 32'd0);
    @(posedge clk); #1;
    b1.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("full_valid", b1.out_valid, 1'b1);
    chk("full_ready", b1.in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", b1.out_valid, 1'b0);
    chk("mrst_ready", b1.in_ready, 1'b1);
    chk("mrst_flag", b1.err_flag, 1'b0);

    // Backpressure, in-order drain, wrap of the 4-bit counter, addr_clr on a pop.
    @(posedge clk); #1;
    b1.in_valid = 1'b1; drv(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0);
    @(posedge clk); #1;
    drv(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'd0);
    @(posedge clk); #1;
    drv(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd0);
    @(negedge clk);
    chk("bp_ready", b1.in_ready, 1'b0);
    @(posedge clk); #1;
    b1.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_w0", b1.out_instr, 32'h000000B3);
    chk("bp_a0", b1.out_addr, 32'h0);
    chk("bp_a0_4", 32'(b2.out_addr), 32'hC);
    @(negedge clk);
    chk("bp_w1", b1.out_instr, 32'h00000133);
    chk("bp_a1", b1.out_addr, 32'h4);
    chk("wrap_4", 32'(b2.out_addr), 32'h0);
    @(posedge clk); #1;
    b1.in_valid = 1'b0; b1.addr_clr = 1'b1;
    @(negedge clk);
    chk("bp_w2", b1.out_instr, 32'h000001B3);
    chk("bp_a2", b1.out_addr, 32'h8);
    @(posedge clk); #1;
    b1.addr_clr = 1'b0; b1.in_valid = 1'b1; drv(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd4, 32'd0);
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_w3", b1.out_instr, 32'h00000233);
    chk("clr_a3", b1.out_addr, 32'h0);
    chk("clr_a3_4", 32'(b2.out_addr), 32'hC);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] imm;
      @(posedge clk); #1;
      case ($urandom_range(0, 4))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = bnd[$urandom_range(0, 13)];
        3: imm = $urandom & 32'hFFFFF000;
        default: imm = 32'($urandom_range(0, 63));
      endcase
      drv(3'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
      b1.in_valid  = ($urandom_range(0, 3) != 0);
      b1.out_ready = ($urandom_range(0, 3) != 0);
      b1.addr_clr  = ($urandom_range(0, 31) == 0);
      rst          = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.addr_clr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
